// File: rtl/cpu_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard logic.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
// Contents: inflight_rec_t (per-stage destination record), forwarding select
// encodings, the XZR register number, and rec_writes() which says whether a
// record will write a given architectural register.
package cpu_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] Rd;
    logic       RegWrite;
    logic       MemToReg;
  } inflight_rec_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam logic [4:0] XZR     = 5'd31;

  // XZR reads as zero, so a write to it is never a real producer.
  function automatic logic rec_writes(inflight_rec_t r, logic [4:0] x);
    return r.valid & r.RegWrite & (r.Rd == x) & (x != XZR);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding-select decode for one EX-stage ALU operand.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
// Ports: src/uses describe the operand of the instruction about to enter EX;
// ex_r/mem_r are the records that will sit in MEM/WB when it does; sel is the
// operand mux select (register file, EX/MEM result or MEM/WB result).
module fwd_select
  import cpu_pkg::*;
(
  input  logic [4:0]    src,
  input  logic          uses,
  input  inflight_rec_t ex_r,
  input  inflight_rec_t mem_r,
  output logic [1:0]    sel
);

  // The younger producer (ex_r) holds the newest value, so it wins.
  always_comb begin
    sel = FWD_RF;
    if (uses && rec_writes(ex_r, src)) begin
      sel = FWD_MEM;
    end else if (uses && rec_writes(mem_r, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, taken-branch squash, EX forwarding selects.
// Latency: stall/flush/bubble combinational; fwdA/fwdB registered (valid in EX).
// Backpressure: stalls PC and IF/ID one cycle per load-use; branch overrides.
// Ports: clk/reset (sync, active-high); id_* describe the ID instruction;
// ex_PC_select flags a taken branch resolved in EX; stall_pc/stall_ifid,
// flush_ifid, bubble_idex steer the front end; fwdA/fwdB select EX operands;
// stall_count/flush_count are saturating performance counters.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_Rn,
  input  logic [4:0]       id_Rm,
  input  logic             id_usesRn,
  input  logic             id_usesRm,
  input  logic [4:0]       id_Rd,
  input  logic             id_RegWrite,
  input  logic             id_MemToReg,
  input  logic             ex_PC_select,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  inflight_rec_t ex_q, ex_d;
  inflight_rec_t mem_q, mem_d;
  inflight_rec_t wb_q, wb_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       ex_is_load;
  logic       load_use;
  logic       stall;
  logic       flush;
  logic       bubble;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  // ex_q/mem_q are the producers that will be in MEM/WB when the ID
  // instruction reaches EX, so they drive the next-cycle selects.
  fwd_select u_fwd_a (
    .src   (id_Rn),
    .uses  (id_usesRn),
    .ex_r  (ex_q),
    .mem_r (mem_q),
    .sel   (sel_a)
  );

  fwd_select u_fwd_b (
    .src   (id_Rm),
    .uses  (id_usesRm),
    .ex_r  (ex_q),
    .mem_r (mem_q),
    .sel   (sel_b)
  );

  always_comb begin
    ex_is_load = ex_q.valid & ex_q.RegWrite & ex_q.MemToReg;
    load_use   = id_valid & ex_is_load &
                 ((id_usesRn & rec_writes(ex_q, id_Rn)) |
                  (id_usesRm & rec_writes(ex_q, id_Rm)));
    flush      = ex_PC_select;
    // A taken branch discards the ID instruction, so there is nothing to stall.
    stall      = load_use & ~ex_PC_select;
    bubble     = stall | flush;

    mem_d = ex_q;
    wb_d  = mem_q;
    ex_d  = '0;
    if (!bubble) begin
      ex_d.valid    = id_valid;
      ex_d.Rd       = id_Rd;
      ex_d.RegWrite = id_RegWrite;
      ex_d.MemToReg = id_MemToReg;
    end

    fwd_a_d = bubble ? FWD_RF : sel_a;
    fwd_b_d = bubble ? FWD_RF : sel_b;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    flush_cnt_d = flush_cnt_q;
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_pc    = stall;
  assign stall_ifid  = stall;
  assign flush_ifid  = flush;
  assign bubble_idex = bubble;
  assign fwdA        = fwd_a_q;
  assign fwdB        = fwd_b_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

`ifndef SYNTHESIS
  // The WB record is kept for debug visibility; it must always be last
  // cycle's MEM record unless a reset intervened.
  wb_follows_mem: assert property (@(posedge clk) disable iff (reset)
    !$past(reset) |-> (wb_q == $past(mem_q)));
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [4:0]       id_Rn, id_Rm, id_Rd;
  logic             id_usesRn, id_usesRm, id_RegWrite, id_MemToReg;
  logic             ex_PC_select;
  logic             stall_pc, stall_ifid, flush_ifid, bubble_idex;
  logic [1:0]       fwdA, fwdB;
  logic [CNT_W-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_Rn        (id_Rn),
    .id_Rm        (id_Rm),
    .id_usesRn    (id_usesRn),
    .id_usesRm    (id_usesRm),
    .id_Rd        (id_Rd),
    .id_RegWrite  (id_RegWrite),
    .id_MemToReg  (id_MemToReg),
    .ex_PC_select (ex_PC_select),
    .stall_pc     (stall_pc),
    .stall_ifid   (stall_ifid),
    .flush_ifid   (flush_ifid),
    .bubble_idex  (bubble_idex),
    .fwdA         (fwdA),
    .fwdB         (fwdB),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  // Reference model: instructions in flight, described by what they write.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       ld;
  } mrec_t;

  typedef struct {
    bit       stall;
    bit       flush;
    bit       bub;
    int       fa;
    int       fb;
    int       sc;
    int       fc;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    n_vec = 0;
  int    n_bad = 0;

  mrec_t m_ex, m_mem, m_wb;
  int    m_fa, m_fb, m_sc, m_fc;

  // Inputs applied during the current cycle, and the model's verdict on them.
  bit       c_rst = 1'b1;
  bit       c_v, c_urn, c_urm, c_rw, c_ld;
  bit [4:0] c_rn, c_rm, c_rd;
  bit       c_stall, c_flush, c_bub;

  bit [4:0] reg_pool [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};

  function automatic bit wr(mrec_t r, bit [4:0] x);
    return r.v && r.rw && (r.rd == x) && (x != 5'd31);
  endfunction

  // Newest producer of the source wins: the one now in EX beats the one in MEM.
  function automatic int pick(bit [4:0] s, bit u, mrec_t newer, mrec_t older);
    if (!u) return 0;
    if (wr(newer, s)) return 1;
    if (wr(older, s)) return 2;
    return 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("stall_pc",    int'(stall_pc),    int'(mon_e.stall));
      chk("stall_ifid",  int'(stall_ifid),  int'(mon_e.stall));
      chk("flush_ifid",  int'(flush_ifid),  int'(mon_e.flush));
      chk("bubble_idex", int'(bubble_idex), int'(mon_e.bub));
      chk("fwdA",        int'(fwdA),        mon_e.fa);
      chk("fwdB",        int'(fwdB),        mon_e.fb);
      chk("stall_count", int'(stall_count), mon_e.sc);
      chk("flush_count", int'(flush_count), mon_e.fc);
    end
  end

  task automatic step(input bit rst, input bit v, input bit [4:0] rn, input bit [4:0] rm,
                      input bit urn, input bit urm, input bit [4:0] rd,
                      input bit rw, input bit ld, input bit br);
    exp_t  e;
    int    nfa, nfb;
    bit    lu;
    @(posedge clk);
    #1;
    // Retire the edge that just happened.
    if (c_rst) begin
      m_ex = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0};
      m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
    end else begin
      nfa = c_bub ? 0 : pick(c_rn, c_urn, m_ex, m_mem);
      nfb = c_bub ? 0 : pick(c_rm, c_urm, m_ex, m_mem);
      m_wb  = m_mem;
      m_mem = m_ex;
      if (c_bub) m_ex = '{default: 0};
      else       m_ex = '{c_v, c_rd, c_rw, c_ld};
      m_fa = nfa;
      m_fb = nfb;
      if (c_stall && m_sc < CMAX) m_sc++;
      if (c_flush && m_fc < CMAX) m_fc++;
    end
    // Present the next cycle's inputs.
    reset = rst; id_valid = v; id_Rn = rn; id_Rm = rm; id_usesRn = urn;
    id_usesRm = urm; id_Rd = rd; id_RegWrite = rw; id_MemToReg = ld;
    ex_PC_select = br;
    lu = v && m_ex.v && m_ex.rw && m_ex.ld &&
         ((urn && wr(m_ex, rn)) || (urm && wr(m_ex, rm)));
    c_rst = rst; c_v = v; c_rn = rn; c_rm = rm; c_urn = urn; c_urm = urm;
    c_rd = rd; c_rw = rw; c_ld = ld;
    c_flush = br;
    c_stall = lu && !br;
    c_bub   = c_stall || c_flush;
    e.stall = c_stall; e.flush = c_flush; e.bub = c_bub;
    e.fa = m_fa; e.fb = m_fb; e.sc = m_sc; e.fc = m_fc;
    exp_q.push_back(e);
  endtask

  task automatic alu(input bit [4:0] rd, input bit [4:0] rn, input bit [4:0] rm,
                     input bit br = 1'b0, input bit rst = 1'b0);
    step(rst, 1'b1, rn, rm, 1'b1, 1'b1, rd, 1'b1, 1'b0, br);
  endtask

  task automatic ldur(input bit [4:0] rd, input bit [4:0] rn);
    step(1'b0, 1'b1, rn, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic nop();
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_Rn = '0; id_Rm = '0; id_Rd = '0;
    id_usesRn = 1'b0; id_usesRm = 1'b0; id_RegWrite = 1'b0; id_MemToReg = 1'b0;
    ex_PC_select = 1'b0;

    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    nop();

    // Back-to-back dependent ALU ops: forward from MEM, no stall.
    alu(5'd1, 5'd2, 5'd3); alu(5'd4, 5'd1, 5'd5); nop(); nop();
    // Load then consumer: one stall, then forward from WB.
    ldur(5'd1, 5'd2); alu(5'd3, 5'd1, 5'd1); alu(5'd3, 5'd1, 5'd1); nop(); nop();
    // XZR never forwards or stalls.
    alu(5'd31, 5'd1, 5'd2); alu(5'd3, 5'd31, 5'd31); nop(); nop();
    ldur(5'd31, 5'd2); alu(5'd3, 5'd31, 5'd31); nop(); nop();
    // Taken branch overrides load-use.
    ldur(5'd1, 5'd2); alu(5'd3, 5'd1, 5'd1, 1'b1); nop(); nop();
    // Two producers of X1 in flight: the newer (MEM) wins.
    alu(5'd1, 5'd2, 5'd3); nop(); alu(5'd1, 5'd2, 5'd3); alu(5'd1, 5'd2, 5'd3);
    alu(5'd5, 5'd1, 5'd1); nop(); nop();
    // Reset during the stall cycle, then the consumer proceeds without a stall.
    ldur(5'd1, 5'd2); alu(5'd3, 5'd1, 5'd1, 1'b0, 1'b1); alu(5'd3, 5'd1, 5'd1); nop();
    // Drive the stall counter into saturation and one step beyond.
    for (int i = 0; i < CMAX + 2; i++) begin
      ldur(5'd1, 5'd2); alu(5'd3, 5'd1, 5'd1); alu(5'd3, 5'd1, 5'd1);
    end
    // Flush counter saturation.
    for (int i = 0; i < CMAX + 2; i++) alu(5'd0, 5'd0, 5'd0, 1'b1);

    // Randomized traffic over a small register pool to make hits likely.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 9) != 0),
           reg_pool[$urandom_range(0, 4)], reg_pool[$urandom_range(0, 4)],
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           reg_pool[$urandom_range(0, 4)],
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0));
    end

    nop();
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
